write_image: RTL

Write-side counterpart of the image reader: accepts an 8-bit pixel stream over a valid/ready handshake, packs pixels into 200-bit words and writes them sequentially into the image buffer memory. The image reader later streams those words out of the same buffer. The block sits between the pixel source (UART/processing stage) and the buffer's write port, and signals frame completion with a one-cycle `done` pulse.

---
 rtl/write_image.sv | 136 +++++++++++++
 1 files changed

// File: rtl/write_image.sv
// Packs an 8-bit pixel stream into 200-bit words and writes them to the image buffer.
// Optional pixel-sum accumulator enabled by defining WRITE_IMAGE_CHECKSUM_EN.
module write_image #(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned WORD_W     = 200,
  parameter int unsigned IMG_PIXELS = 1024,
  parameter int unsigned ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              pix_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [15:0]       checksum
);

  localparam int unsigned PPW = WORD_W / PIX_W;
  localparam int unsigned KW  = $clog2(PPW + 1);
  localparam int unsigned CW  = $clog2(IMG_PIXELS + 1);

  typedef enum logic [1:0] {StIdle, StFill, StWrite, StDone} state_e;

  state_e              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   buf_q, buf_d;
  logic                pix_ready_q, mem_we_q, busy_q, done_q;
  logic                accept;

  assign accept = (state_q == StFill) && pix_valid;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFill;
          k_d     = '0;
          cnt_d   = '0;
          addr_d  = '0;
          buf_d   = '0;
        end
      end
      StFill: begin
        if (pix_valid) begin
          for (int unsigned s = 0; s < PPW; s++) begin
            if (k_q == KW'(s)) buf_d[s*PIX_W +: PIX_W] = pix_data;
          end
          k_d   = k_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (k_q == KW'(PPW - 1) || cnt_q == CW'(IMG_PIXELS - 1)) state_d = StWrite;
        end
      end
      StWrite: begin
        // Buffer must be zero so a partial final word has clean upper slots.
        buf_d = '0;
        k_d   = '0;
        if (cnt_q == CW'(IMG_PIXELS)) begin
          state_d = StDone;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = StFill;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      k_q         <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      buf_q       <= '0;
      pix_ready_q <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      buf_q       <= buf_d;
      pix_ready_q <= (state_d == StFill);
      mem_we_q    <= (state_d == StWrite);
      busy_q      <= (state_d == StFill) || (state_d == StWrite);
      done_q      <= (state_d == StDone);
    end
  end

  assign pix_ready = pix_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = buf_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef WRITE_IMAGE_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == StIdle && start) begin
      csum_d = '0;
    end else if (accept) begin
      csum_d = csum_q + 16'(pix_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign checksum      = '0;
`endif

endmodule
